// File: rtl/radio_timing_sequencer_pkg.sv
// Shared types and default timing constants for the radio front-end sequencer.
package pa_RadioTimingSeq;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PLL_WAIT = 3'd1,
    ARST     = 3'd2,
    ACTIVE   = 3'd3,
    RAMPDOWN = 3'd4,
    ERROR    = 3'd5
  } te_state_t;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_LOAD,
    CNT_INC,
    CNT_DEC
  } te_cnt_op_t;

  localparam int DEF_SIZE_T_ARSTFS    = 8;
  localparam int DEF_PLL_TIMEOUT      = 1023;
  localparam int DEF_RAMP_DOWN_CYCLES = 4;
  localparam int DEF_SIZE_CNT         = 10;

endpackage

// File: rtl/radio_timing_sequencer_cnt.sv
// Shared load/increment/decrement cycle counter; saturates at SAT_MAX and at 0.
module te_cycle_counter
  import pa_RadioTimingSeq::*;
#(
  parameter int SIZE_CNT = DEF_SIZE_CNT,
  parameter int SAT_MAX  = DEF_PLL_TIMEOUT - 1
) (
  input  logic                clk,
  input  logic                rst,
  input  te_cnt_op_t          i_op,
  input  logic [SIZE_CNT-1:0] i_load_val,
  output logic [SIZE_CNT-1:0] o_count
);

  localparam logic [SIZE_CNT-1:0] L_MAX = SIZE_CNT'(SAT_MAX);

  logic [SIZE_CNT-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case (i_op)
        CNT_LOAD: r_count <= i_load_val;
        CNT_INC:  if (r_count < L_MAX) r_count <= r_count + 1'b1;
        CNT_DEC:  if (r_count != '0) r_count <= r_count - 1'b1;
        default:  r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/radio_timing_sequencer.sv
// Radio front-end power sequencer: PLL up, settle, guard time, then PA/LNA;
// orderly ramp-down on disable. Outputs are registered from the next state.
module radio_timing_sequencer
  import pa_RadioTimingSeq::*;
#(
  parameter int SIZE_SPISLAVE_T_ARSTFS = DEF_SIZE_T_ARSTFS,
  parameter int PLL_TIMEOUT            = DEF_PLL_TIMEOUT,
  parameter int RAMP_DOWN_CYCLES       = DEF_RAMP_DOWN_CYCLES,
  parameter int SIZE_CNT               = DEF_SIZE_CNT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              radioEnable,
  input  logic                              radioRxEn,
  input  logic                              pllSettled,
  input  logic [SIZE_SPISLAVE_T_ARSTFS-1:0] tArstFs,
  output logic                              pllEnable,
  output logic                              paEnable,
  output logic                              lnaEnable,
  output logic                              radioReady,
  output logic                              pllTimeout,
  output logic [2:0]                        teState
);

  localparam logic [SIZE_CNT-1:0] L_TO_LAST   = SIZE_CNT'(PLL_TIMEOUT - 1);
  localparam logic [SIZE_CNT-1:0] L_RAMP_LOAD = SIZE_CNT'(RAMP_DOWN_CYCLES - 1);

  te_state_t           r_state;
  logic                r_rx_mode;
  logic                r_pll_timeout;
  logic                r_pll_en, r_pa_en, r_lna_en, r_ready;

  te_state_t           w_nxt_state;
  logic                w_nxt_rx_mode;
  logic                w_nxt_timeout;
  te_cnt_op_t          w_cnt_op;
  logic [SIZE_CNT-1:0] w_cnt_load;
  logic [SIZE_CNT-1:0] w_cnt;
  logic [SIZE_CNT-1:0] w_tarst;
  logic                w_nxt_active;

  assign w_tarst = SIZE_CNT'(tArstFs);

  te_cycle_counter #(
    .SIZE_CNT (SIZE_CNT),
    .SAT_MAX  (PLL_TIMEOUT - 1)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_op       (w_cnt_op),
    .i_load_val (w_cnt_load),
    .o_count    (w_cnt)
  );

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_rx_mode = r_rx_mode;
    w_nxt_timeout = r_pll_timeout;
    w_cnt_op      = CNT_HOLD;
    w_cnt_load    = '0;
    case (r_state)
      IDLE: begin
        if (radioEnable) begin
          w_nxt_state   = PLL_WAIT;
          w_cnt_op      = CNT_LOAD;
          w_nxt_rx_mode = radioRxEn;
          w_nxt_timeout = 1'b0;
        end
      end
      PLL_WAIT: begin
        if (!radioEnable) begin
          w_nxt_state = RAMPDOWN;
          w_cnt_op    = CNT_LOAD;
          w_cnt_load  = L_RAMP_LOAD;
        end else if (pllSettled) begin
          w_nxt_state = ARST;
          w_cnt_op    = CNT_LOAD;
          w_cnt_load  = w_tarst;
        end else if (w_cnt == L_TO_LAST) begin
          w_nxt_state   = ERROR;
          w_nxt_timeout = 1'b1;
        end else begin
          w_cnt_op = CNT_INC;
        end
      end
      ARST: begin
        if (!radioEnable) begin
          w_nxt_state = RAMPDOWN;
          w_cnt_op    = CNT_LOAD;
          w_cnt_load  = L_RAMP_LOAD;
        end else if (w_cnt == '0) begin
          w_nxt_state = ACTIVE;
        end else begin
          w_cnt_op = CNT_DEC;
        end
      end
      ACTIVE: begin
        if (!radioEnable) begin
          w_nxt_state = RAMPDOWN;
          w_cnt_op    = CNT_LOAD;
          w_cnt_load  = L_RAMP_LOAD;
        end else if (!pllSettled) begin
          w_nxt_state   = ERROR;
          w_nxt_timeout = 1'b1;
        end else if (radioRxEn != r_rx_mode) begin
          // Turnaround re-runs the guard time with both PA and LNA off.
          w_nxt_state   = ARST;
          w_cnt_op      = CNT_LOAD;
          w_cnt_load    = w_tarst;
          w_nxt_rx_mode = radioRxEn;
        end
      end
      RAMPDOWN: begin
        if (w_cnt == '0) w_nxt_state = IDLE;
        else             w_cnt_op    = CNT_DEC;
      end
      ERROR: begin
        w_nxt_timeout = 1'b1;
        if (!radioEnable) w_nxt_state = IDLE;
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  assign w_nxt_active = (w_nxt_state == ACTIVE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_rx_mode     <= 1'b0;
      r_pll_timeout <= 1'b0;
      r_pll_en      <= 1'b0;
      r_pa_en       <= 1'b0;
      r_lna_en      <= 1'b0;
      r_ready       <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_rx_mode     <= w_nxt_rx_mode;
      r_pll_timeout <= w_nxt_timeout;
      r_pll_en      <= (w_nxt_state == PLL_WAIT) || (w_nxt_state == ARST) ||
                       (w_nxt_state == ACTIVE)   || (w_nxt_state == RAMPDOWN);
      r_pa_en       <= w_nxt_active && !w_nxt_rx_mode;
      r_lna_en      <= w_nxt_active &&  w_nxt_rx_mode;
      r_ready       <= w_nxt_active;
    end
  end

  assign pllEnable  = r_pll_en;
  assign paEnable   = r_pa_en;
  assign lnaEnable  = r_lna_en;
  assign radioReady = r_ready;
  assign pllTimeout = r_pll_timeout;
  assign teState    = r_state;

endmodule
